// File: rtl/usb_pd_prl_tx.sv
// usb_pd_prl_tx: USB-PD protocol-layer transmit controller.
// Latches a message request, stamps it with the current MessageID, launches
// the PHY writer, waits for a matching GoodCRC and retries on CRCReceiveTimer
// expiry. Hard Reset requests complete as soon as the PHY goes idle.
// Optional feature macro: PRL_TX_STATS_EN (adds stat_retry / stat_fail).
module usb_pd_prl_tx #(
    parameter int system_khz     = 200000,
    parameter int CRC_TIMEOUT_US = 1000,
    parameter int N_RETRY        = 2
) (
    input  logic         clock,
    input  logic         nrst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_hrst,
    input  logic         req_3p1hdr,
    input  logic [2:0]   req_num,
    input  logic [4:0]   req_type,
    input  logic [223:0] req_words,
    input  logic         soft_rst,
    output logic         phy_start,
    input  logic         phy_busy,
    output logic         phy_hrst,
    output logic         phy_3p1hdr,
    output logic [2:0]   phy_id,
    output logic [2:0]   phy_num,
    output logic [4:0]   phy_type,
    output logic [223:0] phy_words,
    input  logic         rx_goodcrc,
    input  logic [2:0]   rx_goodcrc_id,
    output logic         tx_done,
    output logic         tx_fail,
    output logic [2:0]   msg_id
`ifdef PRL_TX_STATS_EN
    ,
    output logic [15:0]  stat_retry,
    output logic [15:0]  stat_fail
`endif
);

    localparam int         TMO_MAX   = system_khz * CRC_TIMEOUT_US / 1000 - 1;
    localparam logic [19:0] TMO_LAST = 20'(TMO_MAX);
    localparam logic [7:0]  RETRY_MAX = 8'(N_RETRY);

    // The CRCReceiveTimer is 20 bits wide; refuse configurations that overflow it.
    generate
        if (TMO_MAX < 0 || TMO_MAX > 1048575) begin : g_tmo_range
            $error("usb_pd_prl_tx: CRC timeout does not fit the 20-bit timer");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, LAUNCH, WAIT_BSY_HI, WAIT_BSY_LO, WAIT_CRC, DONE
    } state_t;

    state_t         state_q, state_d;
    logic           hrst_q, hrst_d;
    logic           p31_q, p31_d;
    logic [2:0]     id_q, id_d;
    logic [2:0]     num_q, num_d;
    logic [4:0]     type_q, type_d;
    logic [223:0]   words_q, words_d;
    logic [7:0]     retry_q, retry_d;
    logic [19:0]    timer_q, timer_d;
    logic           fail_q, fail_d;
    logic [2:0]     msg_id_q, msg_id_d;
    logic           crc_match;

    assign crc_match = rx_goodcrc && (rx_goodcrc_id == id_q);

    // Next-state logic: sequencing, request latch, retry/timeout and MessageID.
    always_comb begin
        state_d  = state_q;
        hrst_d   = hrst_q;
        p31_d    = p31_q;
        id_d     = id_q;
        num_d    = num_q;
        type_d   = type_q;
        words_d  = words_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        fail_d   = fail_q;
        msg_id_d = msg_id_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    hrst_d  = req_hrst;
                    p31_d   = req_3p1hdr;
                    id_d    = msg_id_q;
                    num_d   = req_num;
                    type_d  = req_type;
                    words_d = req_words;
                    retry_d = 8'd0;
                    fail_d  = 1'b0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = WAIT_BSY_HI;
            WAIT_BSY_HI: begin
                if (phy_busy) state_d = WAIT_BSY_LO;
            end
            WAIT_BSY_LO: begin
                if (!phy_busy) begin
                    if (hrst_q) begin
                        // Hard Reset needs no GoodCRC and restarts MessageID.
                        fail_d   = 1'b0;
                        msg_id_d = 3'd0;
                        state_d  = DONE;
                    end else begin
                        timer_d = 20'd0;
                        state_d = WAIT_CRC;
                    end
                end
            end
            WAIT_CRC: begin
                timer_d = 20'(timer_q + 20'd1);
                // A matching GoodCRC beats a coincident timeout.
                if (crc_match) begin
                    fail_d  = 1'b0;
                    state_d = DONE;
                end else if (timer_q == TMO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = 8'(retry_q + 8'd1);
                        state_d = LAUNCH;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!hrst_q) msg_id_d = 3'(msg_id_q + 3'd1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (soft_rst) msg_id_d = 3'd0;
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            hrst_q   <= 1'b0;
            p31_q    <= 1'b0;
            id_q     <= 3'd0;
            num_q    <= 3'd0;
            type_q   <= 5'd0;
            words_q  <= 224'd0;
            retry_q  <= 8'd0;
            timer_q  <= 20'd0;
            fail_q   <= 1'b0;
            msg_id_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            hrst_q   <= hrst_d;
            p31_q    <= p31_d;
            id_q     <= id_d;
            num_q    <= num_d;
            type_q   <= type_d;
            words_q  <= words_d;
            retry_q  <= retry_d;
            timer_q  <= timer_d;
            fail_q   <= fail_d;
            msg_id_q <= msg_id_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign phy_start  = (state_q == LAUNCH);
    assign tx_done    = (state_q == DONE);
    assign tx_fail    = (state_q == DONE) && fail_q;
    assign phy_hrst   = hrst_q;
    assign phy_3p1hdr = p31_q;
    assign phy_id     = id_q;
    assign phy_num    = num_q;
    assign phy_type   = type_q;
    assign phy_words  = words_q;
    assign msg_id     = msg_id_q;

`ifdef PRL_TX_STATS_EN
    logic [15:0] stat_retry_q, stat_retry_d;
    logic [15:0] stat_fail_q, stat_fail_d;

    // Saturating counters of retry launches and failed completions.
    always_comb begin
        stat_retry_d = stat_retry_q;
        stat_fail_d  = stat_fail_q;
        if (state_q == WAIT_CRC && !crc_match && timer_q == TMO_LAST &&
            retry_q < RETRY_MAX && stat_retry_q != 16'hFFFF)
            stat_retry_d = 16'(stat_retry_q + 16'd1);
        if (state_q == DONE && fail_q && stat_fail_q != 16'hFFFF)
            stat_fail_d = 16'(stat_fail_q + 16'd1);
    end

    // Statistics registers, cleared only by the hardware reset.
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            stat_retry_q <= 16'd0;
            stat_fail_q  <= 16'd0;
        end else begin
            stat_retry_q <= stat_retry_d;
            stat_fail_q  <= stat_fail_d;
        end
    end

    assign stat_retry = stat_retry_q;
    assign stat_fail  = stat_fail_q;
`endif

endmodule

// File: tb/tb_usb_pd_prl_tx.sv
// Testbench for usb_pd_prl_tx: plays the PHY writer and the GoodCRC source,
// and predicts MessageID, launch timing and outcome from a transaction-level
// model (attempt plans and a modulo-8 counter).
module tb_usb_pd_prl_tx;

    localparam int KHZ    = 200000;
    localparam int TMO_US = 1;
    localparam int NRET   = 2;
    localparam int TMO    = KHZ * TMO_US / 1000 - 1;   // last timer value: 199

    logic         clock = 1'b0;
    logic         nrst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_hrst = 1'b0;
    logic         req_3p1hdr = 1'b0;
    logic [2:0]   req_num = 3'd0;
    logic [4:0]   req_type = 5'd0;
    logic [223:0] req_words = 224'd0;
    logic         soft_rst = 1'b0;
    logic         phy_start;
    logic         phy_busy = 1'b0;
    logic         phy_hrst;
    logic         phy_3p1hdr;
    logic [2:0]   phy_id;
    logic [2:0]   phy_num;
    logic [4:0]   phy_type;
    logic [223:0] phy_words;
    logic         rx_goodcrc = 1'b0;
    logic [2:0]   rx_goodcrc_id = 3'd0;
    logic         tx_done;
    logic         tx_fail;
    logic [2:0]   msg_id;
`ifdef PRL_TX_STATS_EN
    logic [15:0]  stat_retry;
    logic [15:0]  stat_fail;
`endif

    usb_pd_prl_tx #(
        .system_khz    (KHZ),
        .CRC_TIMEOUT_US(TMO_US),
        .N_RETRY       (NRET)
    ) dut (
        .clock        (clock),
        .nrst         (nrst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_hrst     (req_hrst),
        .req_3p1hdr   (req_3p1hdr),
        .req_num      (req_num),
        .req_type     (req_type),
        .req_words    (req_words),
        .soft_rst     (soft_rst),
        .phy_start    (phy_start),
        .phy_busy     (phy_busy),
        .phy_hrst     (phy_hrst),
        .phy_3p1hdr   (phy_3p1hdr),
        .phy_id       (phy_id),
        .phy_num      (phy_num),
        .phy_type     (phy_type),
        .phy_words    (phy_words),
        .rx_goodcrc   (rx_goodcrc),
        .rx_goodcrc_id(rx_goodcrc_id),
        .tx_done      (tx_done),
        .tx_fail      (tx_fail),
        .msg_id       (msg_id)
`ifdef PRL_TX_STATS_EN
        ,
        .stat_retry   (stat_retry),
        .stat_fail    (stat_fail)
`endif
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_errors = 0;
    int         n_txn = 0;
    logic [2:0] model_id = 3'd0;
    int         model_retries = 0;
    int         model_fails = 0;

    task automatic check(input string tag, input logic [223:0] got, input logic [223:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [223:0] rand_words();
        logic [223:0] w;
        for (int k = 0; k < 7; k++) w[32*k +: 32] = $urandom;
        return w;
    endfunction

    function automatic int rand_plan();
        return ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, TMO + 1));
    endfunction

    task automatic do_reset();
        @(negedge clock);
        nrst = 1'b0;
        phy_busy = 1'b0;
        rx_goodcrc = 1'b0;
        soft_rst = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        nrst = 1'b1;
        model_id = 3'd0;
        model_retries = 0;
        model_fails = 0;
        @(negedge clock);
    endtask

    // One message: p0..p2 give, per attempt, the cycle after busy falls on which
    // a matching GoodCRC is sent (-1 = none). Cycle TMO+1 is the timeout cycle.
    task automatic send(input logic hrst, input logic p31, input logic [2:0] num,
                        input logic [4:0] typ, input logic [223:0] words,
                        input int p0, input int p1, input int p2,
                        input bit decoy, input bit srst_done);
        int         plan [3];
        logic [2:0] exp_id;
        int         att;
        bit         fin;
        bit         got;
        bit         failed;
        plan[0] = p0; plan[1] = p1; plan[2] = p2;
        exp_id = model_id;
        att = 0; fin = 0; failed = 0;

        for (int t = 0; t < 20 && !req_ready; t++) @(negedge clock);
        check("req_ready_idle", {223'd0, req_ready}, 224'd1);
        req_valid = 1'b1; req_hrst = hrst; req_3p1hdr = p31;
        req_num = num; req_type = typ; req_words = words;
        @(negedge clock);
        // Request is no longer sampled; scramble it to prove it was latched.
        req_valid = 1'b0; req_hrst = ~hrst; req_3p1hdr = ~p31;
        req_num = ~num; req_type = ~typ; req_words = ~words;

        while (!fin) begin
            check($sformatf("phy_start_att%0d", att), {223'd0, phy_start}, 224'd1);
            check("phy_fields", {phy_hrst, phy_3p1hdr, phy_id, phy_num, phy_type},
                  {hrst, p31, exp_id, num, typ});
            check("phy_words", phy_words, words);
            @(negedge clock);
            check("start_one_cycle", {223'd0, phy_start}, 224'd0);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            phy_busy = 1'b1;
            if (decoy) begin
                rx_goodcrc = 1'b1;
                rx_goodcrc_id = exp_id;
            end
            @(negedge clock);
            rx_goodcrc = 1'b0;
            repeat ($urandom_range(1, 5)) @(negedge clock);
            phy_busy = 1'b0;
            if (hrst) begin
                @(negedge clock);
                check("hrst_done", {222'd0, tx_done, tx_fail}, {222'd0, 2'b10});
                fin = 1;
            end else begin
                got = 0;
                for (int d = 1; d <= TMO + 1; d++) begin
                    @(negedge clock);
                    rx_goodcrc = 1'b0;
                    if (d == plan[att]) begin
                        rx_goodcrc = 1'b1;
                        rx_goodcrc_id = exp_id;
                        got = 1;
                        break;
                    end else if (decoy && d == 50) begin
                        rx_goodcrc = 1'b1;
                        rx_goodcrc_id = 3'(exp_id + 3'd3);
                    end
                end
                @(negedge clock);
                rx_goodcrc = 1'b0;
                if (got) begin
                    check("ok_done", {222'd0, tx_done, tx_fail}, {222'd0, 2'b10});
                    fin = 1;
                end else if (att < NRET) begin
                    att++;
                end else begin
                    check("fail_done", {222'd0, tx_done, tx_fail}, {222'd0, 2'b11});
                    failed = 1;
                    fin = 1;
                end
            end
        end

        if (srst_done) soft_rst = 1'b1;
        @(negedge clock);
        soft_rst = 1'b0;
        if (srst_done || hrst) model_id = 3'd0;
        else model_id = 3'(model_id + 3'd1);
        model_retries += att;
        if (failed) model_fails++;
        check("msg_id_after", {221'd0, msg_id}, {221'd0, model_id});
        check("idle_after", {222'd0, req_ready, tx_done}, {222'd0, 2'b10});
`ifdef PRL_TX_STATS_EN
        check("stat_retry", {208'd0, stat_retry}, 224'(model_retries));
        check("stat_fail", {208'd0, stat_fail}, 224'(model_fails));
`endif
        $display("txn %0d: hrst=%0d id=%0d launches=%0d fail=%0d msg_id=%0d",
                 n_txn, hrst, exp_id, att + 1, failed, msg_id);
        n_txn++;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_outputs", {phy_start, tx_done, tx_fail, phy_hrst, phy_3p1hdr, msg_id, phy_id, phy_num, phy_type},
              24'd0);
        check("rst_words", phy_words, 224'd0);
        check("rst_ready", {223'd0, req_ready}, 224'd1);
        nrst = 1'b1;
        @(negedge clock);

        // Basic SOP, GoodCRC 100 cycles after busy falls.
        send(1'b0, 1'b0, 3'd0, 5'd1, rand_words(), 100, -1, -1, 1'b0, 1'b0);
        check("msg_id_is_1", {221'd0, msg_id}, 224'd1);

        // Nine successful sends from 0: IDs 0..7 then 0.
        do_reset();
        for (int i = 0; i < 9; i++)
            send(1'b0, 1'($urandom), 3'($urandom), 5'($urandom), rand_words(),
                 int'($urandom_range(1, TMO + 1)), -1, -1, 1'b0, 1'b0);
        check("seq_wrap", {221'd0, msg_id}, 224'd1);

        // No GoodCRC at all: three launches, then failure (msg_id 1 -> 2).
        send(1'b0, 1'b1, 3'd7, 5'd15, rand_words(), -1, -1, -1, 1'b0, 1'b0);

        // phy_id=2: decoy id 5 ignored; match on the timeout cycle wins.
        send(1'b0, 1'b0, 3'd2, 5'd3, rand_words(), TMO + 1, -1, -1, 1'b1, 1'b0);

        // Advance to msg_id 6, then Hard Reset.
        repeat (3) send(1'b0, 1'b0, 3'd1, 5'd2, rand_words(), 10, -1, -1, 1'b0, 1'b0);
        check("pre_hrst_id", {221'd0, msg_id}, 224'd6);
        send(1'b1, 1'b0, 3'd0, 5'd0, rand_words(), -1, -1, -1, 1'b0, 1'b0);

        // soft_rst coincident with the 3rd send's completion.
        send(1'b0, 1'b0, 3'd0, 5'd1, rand_words(), 20, -1, -1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 3'd0, 5'd1, rand_words(), 30, -1, -1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 3'd0, 5'd1, rand_words(), 40, -1, -1, 1'b0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 20; i++)
            send(1'($urandom_range(0, 7) == 0), 1'($urandom), 3'($urandom), 5'($urandom),
                 rand_words(), rand_plan(), rand_plan(), rand_plan(),
                 1'($urandom), 1'($urandom_range(0, 7) == 0));

`ifdef PRL_TX_STATS_EN
        do_reset();
        send(1'b0, 1'b0, 3'd0, 5'd4, rand_words(), -1, -1, -1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 3'd0, 5'd4, rand_words(), -1, -1, -1, 1'b0, 1'b0);
        check("stat_retry_4", {208'd0, stat_retry}, 224'd4);
        check("stat_fail_2", {208'd0, stat_fail}, 224'd2);
`endif

        // nrst asserted while waiting for GoodCRC.
        req_valid = 1'b1; req_hrst = 1'b0; req_num = 3'd1; req_type = 5'd5;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        phy_busy = 1'b1;
        repeat (3) @(negedge clock);
        phy_busy = 1'b0;
        repeat (30) @(negedge clock);
        check("pre_nrst_busy", {222'd0, req_ready, tx_done}, 224'd0);
        nrst = 1'b0;
        #1;
        check("nrst_async", {phy_start, tx_done, req_ready, msg_id}, 6'b001000);
        @(negedge clock);
        nrst = 1'b1;
        model_id = 3'd0; model_retries = 0; model_fails = 0;
        @(negedge clock);
        check("nrst_ready", {222'd0, req_ready, phy_start}, {222'd0, 2'b10});
        send(1'b0, 1'b0, 3'd3, 5'd6, rand_words(), 5, -1, -1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
